clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
- Synthesizable multi-channel clock/timing generator for the CCD SoC. Replaces the behavioural single-output clock_gen model.
- Derives NUM_CH divided clocks from one system clock using per-channel counters.
- Each channel has its own programmable divide ratio and start phase offset.
- Start and stop are glitch-free. A new divide ratio is applied only at a period boundary.
- Outputs drive CCD vertical/horizontal timing and ADC sampling strobes.

Parameters:
- NUM_CH, 4, number of output channels
- DIV_W, 8, width of the divide, phase and duty fields per channel

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable
- ch_en  input  NUM_CH  per-channel enable
- div_i  input  NUM_CH*DIV_W  period in clk cycles; channel i uses bits [i*DIV_W +: DIV_W]
- phase_i  input  NUM_CH*DIV_W  start counter value, sampled only at channel start
- duty_i  input  NUM_CH*DIV_W  high-time in cycles; used only with the optional feature
- clk_o  output  NUM_CH  generated clocks, registered
- per_tick  output  NUM_CH  one-cycle pulse on each period wrap (cnt becomes 0)
- running  output  NUM_CH  1 while channel is RUN or STOPPING
- cfg_err  output  NUM_CH  sticky flag: illegal phase was clamped; cleared by rst only

Behaviour:
- Reset: synchronous, active-high. While rst=1 at an edge, every output register goes to 0:
  - clk_o, per_tick, running, cfg_err = 0
  - all channels IDLE, cnt = 0
- Sanitising (channel i):
  - div_eff = max(div_i, 2)
  - high = div_eff >> 1 (floor)
  - phase_eff = phase_i if phase_i < div_eff; otherwise 0, and cfg_err[i] is set
- States: IDLE, RUN, STOPPING.
- IDLE:
  - clk_o = 0, cnt = 0
  - Start condition: en & ch_en[i] sampled high.
  - On start: cnt <= phase_eff; latch div_eff and high into shadow regs; clk_o <= (phase_eff < high); go to RUN.
  - First clk_o value is therefore visible one cycle after the start condition is sampled.
- RUN:
  - Counter: cnt_next = (cnt == div_sh-1) ? 0 : cnt+1
  - clk_o <= (cnt_next < high_sh)
  - On wrap (cnt_next == 0): per_tick <= 1 and div_sh/high_sh reload from the current inputs. This is the only point a new divide ratio takes effect, so no runt pulse is produced.
  - phase_i is ignored while running.
  - If en or ch_en[i] drops: go to STOPPING; counting continues unchanged.
- STOPPING:
  - Counts exactly as in RUN, so any high pulse in progress completes.
  - At wrap: clk_o <= 0, per_tick <= 0, state <= IDLE, running <= 0.
  - If en & ch_en[i] return before the wrap: go back to RUN with no reload and no discontinuity.
- Alignment: channels started in the same cycle with equal div and phase produce identical edges.
- Simultaneous start/stop on the same edge: the current state's rule applies. IDLE ignores a drop; RUN ignores a rise.
- Reset mid-operation: on the next edge all clk_o are 0 and all channels IDLE. No pulse is completed.
- Channels are fully independent apart from the shared en, clk and rst.

Optional Feature:
- Macro: CLK_GEN_DUTY_EN.
- Defined: high = duty_i, clamped as follows:
  - duty_i = 0 → 1
  - duty_i ≥ div_eff → div_eff-1
  - high is sampled at start and at each wrap, exactly like div.
- Undefined: high = div_eff >> 1. duty_i is present but ignored; no logic is generated for it.

Test Plan:
- rst, then en=1, ch_en=0001, div ch0=4, phase=0 → from the cycle after start, clk_o[0] = 1,1,0,0 repeating; per_tick[0] high every 4th cycle.
- ch1 div=8, phase=2 → clk_o[1] = 1,1,0,0,0,0,1,1,1,1,0,0,...; first per_tick after 6 cycles.
- ch2 div=8 running; drop en while cnt=1 → high continues through cnt=3, low for cnt 4..7, then IDLE with running=0. Re-raise en at cnt=5 instead → stays RUN, no phase jump.
- ch0 div 4→6 changed at cnt=1 → current period stays 4 cycles (1,1,0,0); then 1,1,1,0,0,0.
- div=1, phase=5 on ch3 → treated as div 2, phase 0; clk_o toggles every cycle; cfg_err[3]=1 and stays 1 until rst.
- With CLK_GEN_DUTY_EN, div=10, duty=3 → 3 high / 7 low. duty=0 → 1 high; duty=12 → 9 high. Mid-run rst → all clk_o=0 next cycle.

Source files
------------

// File: rtl/clk_gen_multi_if.sv
// -----------------------------------------------------------------------------
// clk_gen_multi_if
// Control and status bundle for the multi-channel clock/timing generator.
//   en        : global enable
//   ch_en     : per-channel enable
//   div_i     : per-channel period in clk cycles, DIV_W bits per channel
//   phase_i   : per-channel start counter value
//   duty_i    : per-channel high time (used only when CLK_GEN_DUTY_EN is defined)
//   clk_o     : generated clocks (registered)
//   per_tick  : one-cycle pulse when a channel counter wraps to 0
//   running   : channel is RUN or STOPPING
//   cfg_err   : sticky, an illegal start phase was clamped
// master = controller side, slave = generator side.
// -----------------------------------------------------------------------------
interface clk_gen_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);
    logic                      en;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH*DIV_W-1:0]   div_i;
    logic [NUM_CH*DIV_W-1:0]   phase_i;
    logic [NUM_CH*DIV_W-1:0]   duty_i;
    logic [NUM_CH-1:0]         clk_o;
    logic [NUM_CH-1:0]         per_tick;
    logic [NUM_CH-1:0]         running;
    logic [NUM_CH-1:0]         cfg_err;

    modport master (
        output en, ch_en, div_i, phase_i, duty_i,
        input  clk_o, per_tick, running, cfg_err
    );

    modport slave (
        input  en, ch_en, div_i, phase_i, duty_i,
        output clk_o, per_tick, running, cfg_err
    );
endinterface

// File: rtl/clk_gen_multi.sv
// -----------------------------------------------------------------------------
// clk_gen_multi
// Multi-channel divided clock / timing strobe generator. Each channel has an
// independent counter with a programmable period, start phase and (optionally)
// duty. Start and stop are glitch-free; a new period takes effect only when the
// counter wraps.
// Ports:
//   clk : system clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   s   : clk_gen_multi_if.slave (enables, per-channel config, clocks, status)
// Configuration macro:
//   CLK_GEN_DUTY_EN : high time taken from duty_i (clamped to 1..div-1);
//                     when undefined, high time is div/2 and duty_i is ignored.
// -----------------------------------------------------------------------------
module clk_gen_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_gen_multi_if.slave       s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    logic [NUM_CH-1:0] w_clk_o;
    logic [NUM_CH-1:0] w_per_tick;
    logic [NUM_CH-1:0] w_running;
    logic [NUM_CH-1:0] w_cfg_err;

`ifndef CLK_GEN_DUTY_EN
    // duty_i has no function in this build
    logic w_unused_duty;
    assign w_unused_duty = ^s.duty_i;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
        logic [DIV_W-1:0] r_div_sh, w_div_sh_nxt;
        logic [DIV_W-1:0] r_high_sh, w_high_sh_nxt;
        logic             r_clk, w_clk_nxt;
        logic             r_tick, w_tick_nxt;
        logic             r_run, w_run_nxt;
        logic             r_err, w_err_nxt;

        logic [DIV_W-1:0] w_div_raw, w_div_eff, w_high_eff;
        logic [DIV_W-1:0] w_phase_raw, w_phase_eff, w_cnt_inc;
        logic             w_go, w_wrap, w_phase_bad;

        // Sanitise the live configuration for this channel
        assign w_div_raw   = s.div_i[g*DIV_W +: DIV_W];
        assign w_phase_raw = s.phase_i[g*DIV_W +: DIV_W];
        assign w_div_eff   = (w_div_raw < DIV_W'(2)) ? DIV_W'(2) : w_div_raw;
        assign w_phase_bad = (w_phase_raw >= w_div_eff);
        assign w_phase_eff = w_phase_bad ? '0 : w_phase_raw;

`ifdef CLK_GEN_DUTY_EN
        logic [DIV_W-1:0] w_duty_raw;
        assign w_duty_raw = s.duty_i[g*DIV_W +: DIV_W];
        // Keep at least one high and one low cycle per period
        assign w_high_eff = (w_duty_raw == '0)        ? DIV_W'(1) :
                            (w_duty_raw >= w_div_eff) ? w_div_eff - DIV_W'(1) :
                                                        w_duty_raw;
`else
        assign w_high_eff = w_div_eff >> 1;
`endif

        assign w_go      = s.en & s.ch_en[g];
        assign w_wrap    = (r_cnt == r_div_sh - DIV_W'(1));
        assign w_cnt_inc = w_wrap ? '0 : r_cnt + DIV_W'(1);

        // State and output registers
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_div_sh  <= '0;
                r_high_sh <= '0;
                r_clk     <= 1'b0;
                r_tick    <= 1'b0;
                r_run     <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_div_sh  <= w_div_sh_nxt;
                r_high_sh <= w_high_sh_nxt;
                r_clk     <= w_clk_nxt;
                r_tick    <= w_tick_nxt;
                r_run     <= w_run_nxt;
                r_err     <= w_err_nxt;
            end
        end

        // Next state and next register values
        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_div_sh_nxt  = r_div_sh;
            w_high_sh_nxt = r_high_sh;
            w_clk_nxt     = r_clk;
            w_tick_nxt    = 1'b0;
            w_run_nxt     = r_run;
            w_err_nxt     = r_err;

            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    w_clk_nxt = 1'b0;
                    w_run_nxt = 1'b0;
                    if (w_go) begin
                        w_cnt_nxt     = w_phase_eff;
                        w_div_sh_nxt  = w_div_eff;
                        w_high_sh_nxt = w_high_eff;
                        w_clk_nxt     = (w_phase_eff < w_high_eff);
                        w_run_nxt     = 1'b1;
                        w_err_nxt     = r_err | w_phase_bad;
                        w_state_nxt   = ST_RUN;
                    end
                end

                ST_RUN: begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_clk_nxt  = (w_cnt_inc < r_high_sh);
                    w_tick_nxt = w_wrap;
                    // Period boundary is the only place new config is adopted
                    if (w_wrap) begin
                        w_div_sh_nxt  = w_div_eff;
                        w_high_sh_nxt = w_high_eff;
                    end
                    if (!w_go) begin
                        w_state_nxt = ST_STOP;
                    end
                end

                ST_STOP: begin
                    // Finish the current period, then park low
                    w_cnt_nxt = w_cnt_inc;
                    w_clk_nxt = (w_cnt_inc < r_high_sh);
                    if (w_wrap) begin
                        w_cnt_nxt   = '0;
                        w_clk_nxt   = 1'b0;
                        w_run_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else if (w_go) begin
                        w_state_nxt = ST_RUN;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        assign w_clk_o[g]    = r_clk;
        assign w_per_tick[g] = r_tick;
        assign w_running[g]  = r_run;
        assign w_cfg_err[g]  = r_err;
    end

    assign s.clk_o    = w_clk_o;
    assign s.per_tick = w_per_tick;
    assign s.running  = w_running;
    assign s.cfg_err  = w_cfg_err;

endmodule

// File: tb/tb_clk_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_multi
// Directed bench for clk_gen_multi with hand-derived expected waveforms.
// -----------------------------------------------------------------------------
module tb_clk_gen_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    clk_gen_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) u_if ();

    clk_gen_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .s   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int dv, input int ph, input int dt);
        u_if.div_i[ch*DIV_W +: DIV_W]   = DIV_W'(dv);
        u_if.phase_i[ch*DIV_W +: DIV_W] = DIV_W'(ph);
        u_if.duty_i[ch*DIV_W +: DIV_W]  = DIV_W'(dt);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        u_if.en      = 1'b0;
        u_if.ch_en   = '0;
        u_if.div_i   = '0;
        u_if.phase_i = '0;
        u_if.duty_i  = '0;
        tick();
        rst = 1'b0;
    endtask

    // ch0, period 10, given duty; exp_h is the expected high time
    task automatic run_duty(input int dt, input int exp_h);
        do_reset();
        set_ch(0, 10, 0, dt);
        u_if.ch_en = 4'b0001;
        u_if.en    = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("duty%0d_clk_k%0d", dt, k), 32'(u_if.clk_o[0]), 32'(k < exp_h));
            tick();
        end
        check($sformatf("duty%0d_wrap_tick", dt), 32'(u_if.per_tick[0]), 32'd1);
        check($sformatf("duty%0d_wrap_clk", dt), 32'(u_if.clk_o[0]), 32'd1);
    endtask

    initial begin
        logic [7:0]  pat8;
        logic [8:0]  clk9, tick9;
        logic [11:0] clk12, tick12;
        logic [6:0]  clk7, run7;
        logic [10:0] clk11, tick11;
        logic [3:0]  clk4, tick4;

        n_checks = 0;
        n_errors = 0;

        rst          = 1'b1;
        u_if.en      = 1'b0;
        u_if.ch_en   = '0;
        u_if.div_i   = '0;
        u_if.phase_i = '0;
        u_if.duty_i  = '0;
        tick();
        tick();
        check("rst_clk_o",    32'(u_if.clk_o),    32'd0);
        check("rst_per_tick", 32'(u_if.per_tick), 32'd0);
        check("rst_running",  32'(u_if.running),  32'd0);
        check("rst_cfg_err",  32'(u_if.cfg_err),  32'd0);
        rst = 1'b0;
        tick();
        check("idle_clk_o", 32'(u_if.clk_o), 32'd0);

        // ch0 div 4 phase 0: 1,1,0,0 repeating
        set_ch(0, 4, 0, 0);
        u_if.ch_en = 4'b0001;
        u_if.en    = 1'b1;
        tick();
        check("t1_running", 32'(u_if.running), 32'b0001);
        pat8 = 8'b00110011;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_clk_k%0d", k),  32'(u_if.clk_o[0]),    32'(pat8[k]));
            check($sformatf("t1_tick_k%0d", k), 32'(u_if.per_tick[0]), 32'(k == 4));
            tick();
        end
        tick();                         // now at cnt=1
        set_ch(0, 6, 0, 0);
        clk9  = 9'b100011100;
        tick9 = 9'b100000100;
        for (int j = 0; j < 9; j++) begin
            tick();
            check($sformatf("t4_clk_j%0d", j),  32'(u_if.clk_o[0]),    32'(clk9[j]));
            check($sformatf("t4_tick_j%0d", j), 32'(u_if.per_tick[0]), 32'(tick9[j]));
        end
        // Reset while clk_o[0] is high
        rst = 1'b1;
        tick();
        check("midrst_clk_o",   32'(u_if.clk_o),   32'd0);
        check("midrst_running", 32'(u_if.running), 32'd0);

        // ch1 div 8 phase 2
        do_reset();
        set_ch(1, 8, 2, 0);
        u_if.ch_en = 4'b0010;
        u_if.en    = 1'b1;
        tick();
        clk12  = 12'b001111000011;
        tick12 = 12'b000001000000;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t2_clk_k%0d", k),  32'(u_if.clk_o[1]),    32'(clk12[k]));
            check($sformatf("t2_tick_k%0d", k), 32'(u_if.per_tick[1]), 32'(tick12[k]));
            tick();
        end

        // ch2 div 8: drop en at cnt=1, run out the period
        do_reset();
        set_ch(2, 8, 0, 0);
        u_if.ch_en = 4'b0100;
        u_if.en    = 1'b1;
        tick();
        check("t3_start_clk", 32'(u_if.clk_o[2]), 32'd1);
        tick();
        u_if.en = 1'b0;
        clk7 = 7'b0000011;
        run7 = 7'b0111111;
        for (int j = 0; j < 7; j++) begin
            tick();
            check($sformatf("t3_clk_j%0d", j),  32'(u_if.clk_o[2]),    32'(clk7[j]));
            check($sformatf("t3_run_j%0d", j),  32'(u_if.running[2]),  32'(run7[j]));
            check($sformatf("t3_tick_j%0d", j), 32'(u_if.per_tick[2]), 32'd0);
        end
        tick();
        check("t3_idle_run", 32'(u_if.running[2]), 32'd0);

        // Same, but re-raise en at cnt=5
        u_if.en = 1'b1;
        tick();
        tick();
        u_if.en = 1'b0;
        clk11  = 11'b01111000011;
        tick11 = 11'b00001000000;
        for (int j = 0; j < 11; j++) begin
            tick();
            check($sformatf("t3b_clk_j%0d", j),  32'(u_if.clk_o[2]),    32'(clk11[j]));
            check($sformatf("t3b_tick_j%0d", j), 32'(u_if.per_tick[2]), 32'(tick11[j]));
            check($sformatf("t3b_run_j%0d", j),  32'(u_if.running[2]),  32'd1);
            if (j == 3) u_if.en = 1'b1;
        end

        // Alignment: ch0/ch1 div 6 phase 1 started together
        do_reset();
        set_ch(0, 6, 1, 0);
        set_ch(1, 6, 1, 0);
        u_if.ch_en = 4'b0011;
        u_if.en    = 1'b1;
        tick();
        pat8 = 8'b11100011;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("align_k%0d", k), 32'(u_if.clk_o[1:0]), pat8[k] ? 32'd3 : 32'd0);
            tick();
        end

        // ch3 div 1 phase 5 -> div 2 phase 0, cfg_err sticky
        do_reset();
        set_ch(3, 1, 5, 0);
        u_if.ch_en = 4'b1000;
        u_if.en    = 1'b1;
        tick();
        clk4  = 4'b0101;
        tick4 = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_clk_k%0d", k),  32'(u_if.clk_o[3]),    32'(clk4[k]));
            check($sformatf("t5_tick_k%0d", k), 32'(u_if.per_tick[3]), 32'(tick4[k]));
            check($sformatf("t5_err_k%0d", k),  32'(u_if.cfg_err),     32'b1000);
            if (k < 3) tick();
        end
        u_if.ch_en = 4'b0000;
        for (int k = 0; k < 4; k++) tick();
        check("t5_stop_run", 32'(u_if.running[3]), 32'd0);
        check("t5_err_kept", 32'(u_if.cfg_err[3]), 32'd1);
        do_reset();
        check("t5_err_rst", 32'(u_if.cfg_err), 32'd0);

        // Duty handling on ch0, period 10
`ifdef CLK_GEN_DUTY_EN
        run_duty(3, 3);
        run_duty(0, 1);
        run_duty(12, 9);
`else
        run_duty(3, 5);
        run_duty(0, 5);
        run_duty(12, 5);
`endif
        rst = 1'b1;
        tick();
        check("duty_midrst_clk", 32'(u_if.clk_o), 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
